mac_current_accumulator: RTL and testbench

- Upstream feeder for the ReLU neuron stage: accumulates a fixed-length frame of N_INPUTS weighted inputs (x_i * w_i) into a signed accumulator.
- Scales and clamps the sum to an unsigned WIDTH-bit current, then presents it on a valid/ready output that drives the neuron's input_current.
- One result per frame; stream handshake on both sides.

---
 rtl/mac_current_accumulator.sv | 111 +++++++++++
 tb/tb_mac_current_accumulator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_current_accumulator.sv
// Frame-based multiply-accumulate feeding the neuron input current.
// Each frame of N_INPUTS x*w beats produces one scaled, clamped unsigned current.
module mac_current_accumulator #(
  parameter int WIDTH     = 8,
  parameter int N_INPUTS  = 4,
  parameter int ACC_WIDTH = 20,
  parameter int OUT_SHIFT = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                x_in,
  input  logic [WIDTH-1:0]                w_in,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                current_out,
  output logic                            sat_flag,
  output logic [$clog2(N_INPUTS+1)-1:0]   beat_count
);

  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic signed [ACC_WIDTH-1:0] MAX_CUR = ACC_WIDTH'((64'd1 << WIDTH) - 64'd1);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t                       state, state_next;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [CNT_W-1:0]             count;
  logic [WIDTH-1:0]             cur_reg;
  logic                         sat_reg;

  logic signed [2*WIDTH:0]      x_ext, w_ext, prod;
  logic signed [ACC_WIDTH-1:0]  acc_sum, final_sum;
  logic [WIDTH-1:0]             clamp_cur;
  logic                         clamp_sat;
  logic                         accept, last_beat;

  // x is unsigned, so zero-extend it before the signed multiply
  assign x_ext     = {{(WIDTH+1){1'b0}}, x_in};
  assign w_ext     = {{(WIDTH+1){w_in[WIDTH-1]}}, w_in};
  assign prod      = x_ext * w_ext;
  assign acc_sum   = acc + ACC_WIDTH'(prod);
  assign final_sum = acc_sum >>> OUT_SHIFT;

  assign in_ready    = (state == ACCUM);
  assign out_valid   = (state == DONE);
  assign current_out = cur_reg;
  assign sat_flag    = sat_reg;
  assign beat_count  = count;

  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (count == CNT_W'(N_INPUTS - 1));

  always_comb begin
    clamp_cur = final_sum[WIDTH-1:0];
    clamp_sat = 1'b0;
    if (final_sum < 0) begin
      clamp_cur = '0;
      clamp_sat = 1'b1;
    end else if (final_sum > MAX_CUR) begin
      clamp_cur = '1;
      clamp_sat = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (last_beat) state_next = DONE;
        DONE:    if (out_ready) state_next = ACCUM;
        default: state_next = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  // Datapath registers; flush wins over both a beat and an output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      count   <= '0;
      cur_reg <= '0;
      sat_reg <= 1'b0;
    end else if (flush) begin
      acc   <= '0;
      count <= '0;
    end else if (state == ACCUM) begin
      if (accept) begin
        acc   <= acc_sum;
        count <= count + 1'b1;
        if (last_beat) begin
          cur_reg <= clamp_cur;
          sat_reg <= clamp_sat;
        end
      end
    end else if (out_ready) begin
      acc   <= '0;
      count <= '0;
    end
  end

endmodule

// File: tb/tb_mac_current_accumulator.sv
// Self-checking bench: two instances (shift 0 and shift 4) share stimulus and are
// compared against an arithmetic frame model.
module tb_mac_current_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] x_in = '0;
  logic [7:0] w_in = '0;

  logic       in_ready_a, out_valid_a, sat_a;
  logic [7:0] cur_a;
  logic [2:0] cnt_a;
  logic       in_ready_b, out_valid_b, sat_b;
  logic [7:0] cur_b;
  logic [2:0] cnt_b;

  int checks = 0;
  int errors = 0;
  int frame_x[4];
  int frame_w[4];

  always #5 clk = ~clk;

  mac_current_accumulator #(.WIDTH(8), .N_INPUTS(4), .ACC_WIDTH(20), .OUT_SHIFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .x_in(x_in), .w_in(w_in), .flush(flush), .out_valid(out_valid_a),
    .out_ready(out_ready), .current_out(cur_a), .sat_flag(sat_a), .beat_count(cnt_a));

  mac_current_accumulator #(.WIDTH(8), .N_INPUTS(4), .ACC_WIDTH(20), .OUT_SHIFT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .x_in(x_in), .w_in(w_in), .flush(flush), .out_valid(out_valid_b),
    .out_ready(out_ready), .current_out(cur_b), .sat_flag(sat_b), .beat_count(cnt_b));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_result(input int sum, input int sh, output int cur, output bit sat);
    int f;
    f = sum >>> sh;
    if (f < 0) begin
      cur = 0; sat = 1'b1;
    end else if (f > 255) begin
      cur = 255; sat = 1'b1;
    end else begin
      cur = f; sat = 1'b0;
    end
  endfunction

  task automatic send_beat(input int x, input int w);
    in_valid = 1'b1;
    x_in = x[7:0];
    w_in = w[7:0];
    step();
    in_valid = 1'b0;
  endtask

  // Plays frame_x/frame_w, stalls the output for 'hold' cycles, then handshakes
  task automatic test_frame(input string name, input int hold, input bit gaps);
    int sum, cur0, cur4;
    bit sat0, sat4;
    sum = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        int idle = $urandom_range(0, 2);
        for (int k = 0; k < idle; k++) step();
      end
      sum += frame_x[i] * frame_w[i];
      send_beat(frame_x[i], frame_w[i]);
      if (i < 3) begin
        checks++;
        if ({out_valid_a, cnt_a, out_valid_b, cnt_b} !== {1'b0, 3'(i + 1), 1'b0, 3'(i + 1)}) begin
          errors++;
          $display("FAIL %s beat%0d: valid/cnt a=%0b/%0d b=%0b/%0d required 0/%0d",
                   name, i, out_valid_a, cnt_a, out_valid_b, cnt_b, i + 1);
        end
      end
    end
    ref_result(sum, 0, cur0, sat0);
    ref_result(sum, 4, cur4, sat4);
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if ({out_valid_a, in_ready_a, sat_a, cur_a, cnt_a} !== {1'b1, 1'b0, sat0, 8'(cur0), 3'd4}) begin
        errors++;
        $display("FAIL %s result_s0 cyc%0d: valid=%0b rdy=%0b sat=%0b cur=%0d cnt=%0d required 1 0 %0b %0d 4 (sum %0d)",
                 name, h, out_valid_a, in_ready_a, sat_a, cur_a, cnt_a, sat0, cur0, sum);
      end
      checks++;
      if ({out_valid_b, in_ready_b, sat_b, cur_b} !== {1'b1, 1'b0, sat4, 8'(cur4)}) begin
        errors++;
        $display("FAIL %s result_s4 cyc%0d: valid=%0b rdy=%0b sat=%0b cur=%0d required 1 0 %0b %0d (sum %0d)",
                 name, h, out_valid_b, in_ready_b, sat_b, cur_b, sat4, cur4, sum);
      end
      if (h < hold) begin
        // beats offered while stalled must be ignored
        send_beat($urandom_range(0, 255), $urandom_range(0, 255));
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if ({out_valid_a, in_ready_a, cnt_a, out_valid_b, in_ready_b} !== {1'b0, 1'b1, 3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s handshake: valid=%0b rdy=%0b cnt=%0d (b valid=%0b rdy=%0b) required 0 1 0",
               name, out_valid_a, in_ready_a, cnt_a, out_valid_b, in_ready_b);
    end
    $display("frame %s sum=%0d cur_s0=%0d sat_s0=%0b cur_s4=%0d sat_s4=%0b", name, sum, cur0, sat0, cur4, sat4);
  endtask

  task automatic set_frame(input int x0, x1, x2, x3, w0, w1, w2, w3);
    frame_x = '{x0, x1, x2, x3};
    frame_w = '{w0, w1, w2, w3};
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid_a, sat_a, cur_a, cnt_a} !== {1'b0, 1'b0, 8'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_state: valid=%0b sat=%0b cur=%0d cnt=%0d required 0 0 0 0",
               out_valid_a, sat_a, cur_a, cnt_a);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({in_ready_a, out_valid_a, in_ready_b, out_valid_b} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_release: rdy=%0b valid=%0b required 1 0", in_ready_a, out_valid_a);
    end
    $display("reset checked");
  endtask

  task automatic test_directed;
    set_frame(10, 20, 30, 40, 1, 2, -1, 3);
    test_frame("basic140", 0, 0);
    set_frame(255, 255, 255, 255, 127, 127, 127, 127);
    test_frame("sat_high", 0, 0);
    set_frame(100, 100, 100, 100, -5, -5, -5, -5);
    test_frame("sat_low", 0, 0);
    set_frame(1, 0, 0, 0, -1, 0, 0, 0);
    test_frame("minus_one", 0, 0);
  endtask

  task automatic test_backpressure;
    set_frame(10, 20, 30, 40, 1, 2, -1, 3);
    test_frame("stall5", 5, 0);
    test_frame("after_stall", 0, 0);
  endtask

  task automatic test_flush;
    send_beat(50, 100);
    send_beat(60, -100);
    flush = 1'b1;
    send_beat(200, 100);
    flush = 1'b0;
    checks++;
    if ({out_valid_a, in_ready_a, cnt_a} !== {1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL flush_mid: valid=%0b rdy=%0b cnt=%0d required 0 1 0", out_valid_a, in_ready_a, cnt_a);
    end
    set_frame(1, 2, 3, 4, 1, 1, 1, 1);
    test_frame("after_flush", 0, 0);
    for (int i = 0; i < 4; i++) send_beat(90, 90);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({out_valid_a, in_ready_a, cnt_a} !== {1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL flush_done: valid=%0b rdy=%0b cnt=%0d required 0 1 0", out_valid_a, in_ready_a, cnt_a);
    end
    test_frame("after_flush_done", 0, 0);
  endtask

  task automatic test_reset_mid;
    send_beat(77, 33);
    send_beat(12, -7);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid_a, cnt_a, cnt_b} !== {1'b0, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_mid: valid=%0b cnt_a=%0d cnt_b=%0d required 0 0 0", out_valid_a, cnt_a, cnt_b);
    end
    step();
    rst_n = 1'b1;
    step();
    set_frame(10, 20, 30, 40, 1, 2, -1, 3);
    test_frame("after_reset_mid", 0, 0);
  endtask

  task automatic test_random;
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < 4; i++) begin
        frame_x[i] = $urandom_range(0, 255);
        frame_w[i] = int'($urandom_range(0, 255)) - 128;
        if (f % 3 == 0) frame_w[i] = int'($urandom_range(0, 6)) - 3;
      end
      test_frame($sformatf("rand%0d", f), $urandom_range(0, 3), 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
